if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//  Instruction-fetch front end that drives the icache controller and consumes its output.
//  - Holds the fetch PC and presents it as proc2Icache_addr.
//  - On an icache hit, extracts one or two 32-bit instructions from the 64-bit line.
//  - Buffers instructions in a circular FIFO that feeds decode over a valid/ready handshake.
//  - A redirect (branch/exception) flushes the FIFO and reloads the PC.
// PARAMETERS
//  QUEUE_IDX_BITS  3      log2 of FIFO depth
//  QUEUE_DEPTH     8      FIFO entries; must equal 1<<QUEUE_IDX_BITS
//  RESET_PC        64'h0  fetch PC loaded on reset
// PORTS
//  clock             in   1   system clock, all state updates on posedge
//  reset             in   1   synchronous, active-high
//  Icache_data_out   in   64  line data for proc2Icache_addr[63:3]
//  Icache_valid_out  in   1   Icache_data_out valid this cycle (hit)
//  redirect_valid    in   1   flush queue and load redirect_pc
//  redirect_pc       in   64  new fetch PC
//  id_ready          in   1   decode accepts if_inst this cycle
//  proc2Icache_addr  out  64  current fetch PC (registered)
//  if_inst           out  32  FIFO head instruction
//  if_pc             out  64  PC of head instruction
//  if_npc            out  64  if_pc + 4
//  if_valid          out  1   FIFO head valid (not empty)
//  queue_count       out  QUEUE_IDX_BITS+1  occupied entries, 0..QUEUE_DEPTH
// BEHAVIOUR
//  Reset
//  - Values: PC=RESET_PC, head=tail=0, count=0, if_valid=0.
//  - When empty: if_inst=32'h47ff041f (NOP), if_pc=if_npc=0.
//  Outputs
//  - All outputs are driven from registers only; no combinational path from inputs.
//  Instruction extraction
//  - PC[2]=0 selects data[31:0].
//  - PC[2]=1 selects data[63:32].
//  Push rule (no redirect)
//  - Free slots are computed before this cycle's pop: free = QUEUE_DEPTH - count.
//  - Icache_valid_out=1, PC[2]=0, free>=2: push data[31:0] (pc=PC), then data[63:32] (pc=PC+4); PC<=PC+8.
//  - Icache_valid_out=1 with (PC[2]=1 or free==1): push one instruction; PC<=PC+4.
//  - Icache_valid_out=0 or free==0: no push; PC holds, so proc2Icache_addr stays stable for the miss.
//  Pop rule
//  - if_valid & id_ready removes the head; head advances by 1.
//  - A pop and a push in the same cycle are both legal.
//  - Result: count <= count - pop + pushes (0..2).
//  Pointers
//  - head/tail are QUEUE_IDX_BITS wide and wrap modulo QUEUE_DEPTH.
//  - count is tracked separately, so full and empty are never ambiguous.
//  Redirect (highest priority)
//  - Effect: head=tail=count=0, PC<={redirect_pc[63:2],2'b00}.
//  - The cycle's push is dropped. The pop is a no-op; decode squashes it itself.
//  - Timing: if_valid=0 on the next cycle. The first fetch at the new PC is issued on the next cycle.
//  Reset precedence
//  - reset overrides redirect and clears state mid-operation.
//  Arithmetic
//  - PC arithmetic is 64-bit unsigned and wraps at 2^64.
//  - Each entry stores {inst[31:0], pc[63:2]}; if_npc is computed from the stored pc.
// TESTING
//  T1 Reset:
//     - reset=1 for 2 cycles, then release.
//     - Expect proc2Icache_addr=0, queue_count=0, if_valid=0, if_inst=32'h47ff041f.
//  T2 Dual push:
//     - PC=0, empty queue, hit with data=64'hBBBBBBBB_AAAAAAAA.
//     - Next cycle: count=2, PC=8, if_inst=AAAAAAAA, if_pc=0, if_npc=4.
//  T3 Single push:
//     - PC=0x10, count=7, id_ready=0, hit.
//     - Expect one push (low word), count=8, PC=0x14.
//     - Following hit: no push, PC holds at 0x14.
//  T4 Full with pop:
//     - count=8, id_ready=1, hit at PC[2]=0.
//     - Expect no push (free=0), count=7.
//     - Next cycle: free=1, single push, count stays 7 with continued pop.
//  T5 Miss stall:
//     - Icache_valid_out=0 for 5 cycles at PC=0x40, id_ready=1, count=3.
//     - Expect PC stays 0x40 and count drains to 0, with if_valid=0 at count 0.
//  T6 Redirect:
//     - count=5 with hit and id_ready=1, plus redirect_valid=1, redirect_pc=0x103.
//     - Next cycle: count=0, if_valid=0, proc2Icache_addr=0x100.
//     - Wrap check: 20 pushes/pops with head/tail wrapping; if_pc sequence strictly +4.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: holds the fetch PC, splits 64-bit icache lines into
// 32-bit instructions and buffers them in a circular FIFO that feeds decode.
module if_fetch_queue #(
    parameter int          QUEUE_IDX_BITS = 3,
    parameter int          QUEUE_DEPTH    = 8,
    parameter logic [63:0] RESET_PC       = 64'h0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [63:0]               Icache_data_out,
    input  logic                      Icache_valid_out,
    input  logic                      redirect_valid,
    input  logic [63:0]               redirect_pc,
    input  logic                      id_ready,
    output logic [63:0]               proc2Icache_addr,
    output logic [31:0]               if_inst,
    output logic [63:0]               if_pc,
    output logic [63:0]               if_npc,
    output logic                      if_valid,
    output logic [QUEUE_IDX_BITS:0]   queue_count
);

    localparam int          CW       = QUEUE_IDX_BITS + 1;
    localparam logic [31:0] NOP_INST = 32'h47ff041f;

    typedef logic [QUEUE_IDX_BITS-1:0] idx_t;

    logic [63:0]   pc_reg, pc_next;
    idx_t          head_reg, head_next;
    idx_t          tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;

    // Each entry keeps the instruction word and its word-aligned PC.
    logic [31:0]   inst_mem [QUEUE_DEPTH];
    logic [61:0]   pc_mem   [QUEUE_DEPTH];

    logic [CW-1:0] free_slots;
    logic          do_pop;
    logic          push_one;
    logic          push_two;
    logic [1:0]    push_cnt;
    logic [31:0]   first_inst;
    logic [61:0]   second_pc_word;
    logic [63:0]   redirect_aligned;
    idx_t          tail_plus1;
    logic [63:0]   head_pc;

    logic [QUEUE_DEPTH-1:0] wr_first;
    logic [QUEUE_DEPTH-1:0] wr_second;

    // Free space is judged before this cycle's pop, so a full queue never pushes.
    assign free_slots       = CW'(QUEUE_DEPTH) - count_reg;
    assign do_pop           = (count_reg != '0) & id_ready;
    assign push_two         = ~redirect_valid & Icache_valid_out & ~pc_reg[2]
                              & (free_slots >= CW'(2));
    assign push_one         = ~redirect_valid & Icache_valid_out & ~push_two
                              & (free_slots != '0);
    assign push_cnt         = push_two ? 2'd2 : (push_one ? 2'd1 : 2'd0);
    assign first_inst       = pc_reg[2] ? Icache_data_out[63:32] : Icache_data_out[31:0];
    assign second_pc_word   = pc_reg[63:2] + 62'd1;
    assign redirect_aligned = redirect_pc & ~64'h3;
    assign tail_plus1       = tail_reg + idx_t'(1);

    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_wr_sel
            assign wr_first[gi]  = (push_one | push_two) & (tail_reg == idx_t'(gi));
            assign wr_second[gi] = push_two & (tail_plus1 == idx_t'(gi));
        end
    endgenerate

    always_comb begin
        pc_next    = pc_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (redirect_valid) begin
            pc_next    = redirect_aligned;
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            pc_next    = pc_reg + (64'(push_cnt) << 2);
            head_next  = head_reg + idx_t'(do_pop);
            tail_next  = tail_reg + idx_t'(push_cnt);
            count_next = count_reg - CW'(do_pop) + CW'(push_cnt);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg    <= RESET_PC;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            pc_reg    <= pc_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry storage needs no reset: the count gates everything read from it.
    always_ff @(posedge clock) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (wr_first[i]) begin
                inst_mem[i] <= first_inst;
                pc_mem[i]   <= pc_reg[63:2];
            end else if (wr_second[i]) begin
                inst_mem[i] <= Icache_data_out[63:32];
                pc_mem[i]   <= second_pc_word;
            end
        end
    end

    assign head_pc          = {pc_mem[head_reg], 2'b00};
    assign proc2Icache_addr = pc_reg;
    assign queue_count      = count_reg;
    assign if_valid         = (count_reg != '0);
    assign if_inst          = if_valid ? inst_mem[head_reg] : NOP_INST;
    assign if_pc            = if_valid ? head_pc : 64'h0;
    assign if_npc           = if_valid ? head_pc + 64'd4 : 64'h0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus random traffic,
// all checked against a queue-level reference model of the fetch front end.
module tb_if_fetch_queue;

    localparam logic [31:0] NOP_INST = 32'h47ff041f;

    logic        clock;
    logic        reset;
    logic [63:0] Icache_data_out;
    logic        Icache_valid_out;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_ready;
    logic [63:0] proc2Icache_addr;
    logic [31:0] if_inst;
    logic [63:0] if_pc;
    logic [63:0] if_npc;
    logic        if_valid;
    logic [3:0]  queue_count;

    if_fetch_queue #(
        .QUEUE_IDX_BITS (3),
        .QUEUE_DEPTH    (8),
        .RESET_PC       (64'h0)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .Icache_data_out  (Icache_data_out),
        .Icache_valid_out (Icache_valid_out),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .id_ready         (id_ready),
        .proc2Icache_addr (proc2Icache_addr),
        .if_inst          (if_inst),
        .if_pc            (if_pc),
        .if_npc           (if_npc),
        .if_valid         (if_valid),
        .queue_count      (queue_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic [63:0] m_pc;
    int          vectors     = 0;
    int          miscompares = 0;

    wire [228:0] obs_vec = {proc2Icache_addr, queue_count, if_valid, if_inst, if_pc, if_npc};

    // Expected outputs from the model: {addr, count, valid, inst, pc, npc}.
    function automatic logic [228:0] exp_vec();
        logic [31:0] i;
        logic [63:0] p;
        logic [63:0] n;
        logic        v;
        v = (m_q.size() != 0);
        if (v) begin
            i = m_q[0].inst;
            p = m_q[0].pc;
            n = p + 64'd4;
        end else begin
            i = NOP_INST;
            p = 64'h0;
            n = 64'h0;
        end
        return {m_pc, 4'(m_q.size()), v, i, p, n};
    endfunction

    // Apply one clock of stimulus and advance the reference model.
    task automatic cycle(input logic rst, input logic hit, input logic [63:0] data,
                         input logic rdy, input logic rdv, input logic [63:0] rpc);
        int   free;
        ent_t e;
        reset            = rst;
        Icache_valid_out = hit;
        Icache_data_out  = data;
        id_ready         = rdy;
        redirect_valid   = rdv;
        redirect_pc      = rpc;
        @(posedge clock);
        if (rst) begin
            m_pc = 64'h0;
            m_q.delete();
        end else if (rdv) begin
            m_pc = {rpc[63:2], 2'b00};
            m_q.delete();
        end else begin
            free = 8 - m_q.size();
            if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
            if (hit && free > 0) begin
                if (!m_pc[2] && free >= 2) begin
                    e.inst = data[31:0];  e.pc = m_pc;         m_q.push_back(e);
                    e.inst = data[63:32]; e.pc = m_pc + 64'd4; m_q.push_back(e);
                    m_pc = m_pc + 64'd8;
                end else begin
                    e.inst = m_pc[2] ? data[63:32] : data[31:0];
                    e.pc   = m_pc;
                    m_q.push_back(e);
                    m_pc = m_pc + 64'd4;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
        cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, {$urandom, $urandom}, 1'b1, 1'b1, 64'h1234);
        cycle(1'b1, 1'b1, {$urandom, $urandom}, 1'b1, 1'b1, 64'h5678);
        vectors++;
        if ({proc2Icache_addr, queue_count, if_valid, if_inst, if_pc, if_npc} !==
            {64'h0, 4'd0, 1'b0, NOP_INST, 64'h0, 64'h0}) begin
            $display("FAIL reset_state: got %h want %h", obs_vec,
                     {64'h0, 4'd0, 1'b0, NOP_INST, 64'h0, 64'h0});
            miscompares++;
        end
    endtask

    task automatic test_dual_push();
        do_reset();
        cycle(1'b0, 1'b1, 64'hBBBBBBBB_AAAAAAAA, 1'b0, 1'b0, 64'h0);
        vectors++;
        if ({queue_count, proc2Icache_addr, if_inst, if_pc, if_npc} !==
            {4'd2, 64'h8, 32'hAAAAAAAA, 64'h0, 64'h4}) begin
            $display("FAIL dual_push: got cnt=%0d addr=%h inst=%h pc=%h npc=%h want 2/8/AAAAAAAA/0/4",
                     queue_count, proc2Icache_addr, if_inst, if_pc, if_npc);
            miscompares++;
        end
        cycle(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
        vectors++;
        if ({queue_count, if_inst, if_pc, if_npc} !== {4'd1, 32'hBBBBBBBB, 64'h4, 64'h8}) begin
            $display("FAIL dual_push_hi: got cnt=%0d inst=%h pc=%h npc=%h want 1/BBBBBBBB/4/8",
                     queue_count, if_inst, if_pc, if_npc);
            miscompares++;
        end
    endtask

    task automatic test_single_push();
        do_reset();
        // Start just below the 2^64 wrap so the fill reaches PC=0x10 with 7 entries.
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 64'h0);
            vectors++;
            if (obs_vec !== exp_vec()) begin
                $display("FAIL single_fill[%0d]: got %h want %h", k, obs_vec, exp_vec());
                miscompares++;
            end
        end
        vectors++;
        if ({queue_count, proc2Icache_addr, if_pc} !== {4'd7, 64'h10, 64'hFFFF_FFFF_FFFF_FFF4}) begin
            $display("FAIL single_setup: got cnt=%0d addr=%h pc=%h want 7/10/fffffffffffffff4",
                     queue_count, proc2Icache_addr, if_pc);
            miscompares++;
        end
        cycle(1'b0, 1'b1, 64'h22222222_11111111, 1'b0, 1'b0, 64'h0);
        vectors++;
        if ({queue_count, proc2Icache_addr} !== {4'd8, 64'h14}) begin
            $display("FAIL single_push: got cnt=%0d addr=%h want 8/14", queue_count, proc2Icache_addr);
            miscompares++;
        end
        cycle(1'b0, 1'b1, 64'h44444444_33333333, 1'b0, 1'b0, 64'h0);
        vectors++;
        if ({queue_count, proc2Icache_addr} !== {4'd8, 64'h14}) begin
            $display("FAIL full_hold: got cnt=%0d addr=%h want 8/14", queue_count, proc2Icache_addr);
            miscompares++;
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 64'h0);
        cycle(1'b0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 64'h0);
        vectors++;
        if ({queue_count, proc2Icache_addr} !== {4'd7, 64'h20} || obs_vec !== exp_vec()) begin
            $display("FAIL full_pop: got cnt=%0d addr=%h want 7/20", queue_count, proc2Icache_addr);
            miscompares++;
        end
        cycle(1'b0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 64'h0);
        vectors++;
        if ({queue_count, proc2Icache_addr} !== {4'd7, 64'h24} || obs_vec !== exp_vec()) begin
            $display("FAIL full_pop_refill: got cnt=%0d addr=%h want 7/24", queue_count, proc2Icache_addr);
            miscompares++;
        end
    endtask

    task automatic test_miss_stall();
        int exp_cnt;
        do_reset();
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h34);
        cycle(1'b0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 64'h0);
        cycle(1'b0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 64'h0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, {$urandom, $urandom}, 1'b1, 1'b0, 64'h0);
            exp_cnt = (k < 3) ? 2 - k : 0;
            vectors++;
            if ({proc2Icache_addr, queue_count, if_valid} !== {64'h40, 4'(exp_cnt), exp_cnt != 0}) begin
                $display("FAIL miss_stall[%0d]: got addr=%h cnt=%0d valid=%b want 40/%0d/%b",
                         k, proc2Icache_addr, queue_count, if_valid, exp_cnt, exp_cnt != 0);
                miscompares++;
            end
        end
        vectors++;
        if (if_inst !== NOP_INST) begin
            $display("FAIL miss_nop: got %h want %h", if_inst, NOP_INST);
            miscompares++;
        end
    endtask

    task automatic test_redirect();
        logic [63:0] exp_head;
        do_reset();
        cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h4);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 64'h0);
        vectors++;
        if (queue_count !== 4'd5) begin
            $display("FAIL redirect_setup: got cnt=%0d want 5", queue_count);
            miscompares++;
        end
        cycle(1'b0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b1, 64'h103);
        vectors++;
        if ({queue_count, if_valid, proc2Icache_addr} !== {4'd0, 1'b0, 64'h100}) begin
            $display("FAIL redirect: got cnt=%0d valid=%b addr=%h want 0/0/100",
                     queue_count, if_valid, proc2Icache_addr);
            miscompares++;
        end
        cycle(1'b0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 64'h0);
        vectors++;
        if ({queue_count, if_pc, proc2Icache_addr} !== {4'd2, 64'h100, 64'h108}) begin
            $display("FAIL redirect_fetch: got cnt=%0d pc=%h addr=%h want 2/100/108",
                     queue_count, if_pc, proc2Icache_addr);
            miscompares++;
        end
        // Steady fetch and drain: pointers wrap several times, head PC must step by 4.
        exp_head = 64'h100;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 64'h0);
            exp_head = exp_head + 64'd4;
            vectors++;
            if (if_pc !== exp_head || obs_vec !== exp_vec()) begin
                $display("FAIL wrap[%0d]: got pc=%h state=%h want pc=%h state=%h",
                         k, if_pc, obs_vec, exp_head, exp_vec());
                miscompares++;
            end
        end
    endtask

    task automatic test_random();
        logic rst, hit, rdy, rdv;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(63) == 0);
            rdv = ($urandom_range(15) == 0);
            hit = ($urandom_range(3) != 0);
            rdy = ($urandom_range(2) != 0);
            cycle(rst, hit, {$urandom, $urandom}, rdy, rdv, {$urandom, $urandom});
            vectors++;
            if (obs_vec !== exp_vec()) begin
                $display("FAIL random[%0d]: got %h want %h", k, obs_vec, exp_vec());
                miscompares++;
            end
        end
    endtask

    initial begin
        reset            = 1'b1;
        Icache_data_out  = 64'h0;
        Icache_valid_out = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = 64'h0;
        id_ready         = 1'b0;
        m_pc             = 64'h0;
        test_reset();
        test_dual_push();
        test_single_push();
        test_full_pop();
        test_miss_stall();
        test_redirect();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
